// File: rtl/chip8_call_ret_unit.sv
// chip8_call_ret_unit: CHIP-8 CALL/RET sequencer driving an external return-address stack.
module chip8_call_ret_unit #(
    parameter int STACK_DEPTH = 16,
    localparam int DW = $clog2(STACK_DEPTH + 1)
) (
    input  logic          cpu_clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [15:0]   opcode,
    input  logic [11:0]   pc,
    output logic [1:0]    stk_we,
    output logic [15:0]   stk_writedata,
    input  logic [15:0]   stk_outdata,
    output logic          busy,
    output logic          done,
    output logic          pc_load,
    output logic [11:0]   pc_next,
    output logic [DW-1:0] depth,
    output logic          fault
);
    typedef enum logic [2:0] {IDLE, PUSH, POP, POP_WAIT, DONE} state_t;
    localparam logic [DW-1:0] DMAX = DW'(STACK_DEPTH);
    state_t state, state_n;
    logic is_call, is_ret, call_ok, ret_ok, load_q;
    assign is_call = opcode[15:12] == 4'h2;
    assign is_ret  = opcode == 16'h00EE;
    assign call_ok = is_call && depth != DMAX;
    assign ret_ok  = is_ret && depth != '0;
    assign busy    = state != IDLE;
    assign done    = state == DONE;
    assign pc_load = done && load_q;
    assign stk_we  = state == PUSH ? 2'b01 : state == POP ? 2'b10 : 2'b00;
    always_ff @(posedge cpu_clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end
    always_comb begin
        state_n = state == IDLE     ? (start ? (call_ok ? PUSH : ret_ok ? POP : DONE) : IDLE) :
                  state == PUSH     ? DONE :
                  state == POP      ? POP_WAIT :
                  state == POP_WAIT ? DONE : IDLE;
    end
    // Request fields are folded into the push word, jump target and load flag at acceptance.
    always_ff @(posedge cpu_clk) begin
        if (!reset_n) begin
            depth         <= '0;
            fault         <= 1'b0;
            load_q        <= 1'b0;
            pc_next       <= '0;
            stk_writedata <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    load_q <= call_ok || ret_ok;
                    fault  <= fault | (is_call && !call_ok) | (is_ret && !ret_ok);
                    if (call_ok) begin
                        pc_next       <= opcode[11:0];
                        stk_writedata <= {4'h0, pc + 12'd2};
                    end
                end
                PUSH:     depth   <= depth + 1'b1;
                POP:      depth   <= depth - 1'b1;
                POP_WAIT: pc_next <= stk_outdata[11:0];
                default: ;
            endcase
        end
    end
endmodule
